// File: rtl/multiword_add_ctrl_pkg.sv
// multiword_add_ctrl_pkg: shared slice width and controller state encoding
package multiword_add_ctrl_pkg;
    localparam int SLICE_W = 16;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/multiword_add_ctrl_carry_select_adder.sv
// carry_select_adder: 16-bit adder, upper half precomputed for both carries and selected by the lower carry
module carry_select_adder
    import multiword_add_ctrl_pkg::*;
(
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               cin,
    output logic [SLICE_W-1:0] sum,
    output logic               cout
);
    localparam int H = SLICE_W / 2;
    logic [H:0] lo, hi0, hi1;
    assign lo  = {1'b0, a[H-1:0]} + {1'b0, b[H-1:0]} + {{H{1'b0}}, cin};
    assign hi0 = {1'b0, a[SLICE_W-1:H]} + {1'b0, b[SLICE_W-1:H]};
    assign hi1 = hi0 + {{H{1'b0}}, 1'b1};
    assign {cout, sum} = lo[H] ? {hi1, lo[H-1:0]} : {hi0, lo[H-1:0]};
endmodule

// File: rtl/multiword_add_ctrl.sv
// multiword_add_ctrl: wide add run one 16-bit slice per cycle through a single shared adder.
// Define MULTIWORD_ADD_SUB_EN to enable A-B via the sub input (otherwise sub is ignored).
module multiword_add_ctrl
    import multiword_add_ctrl_pkg::*;
#(
    parameter  int WORDS = 4,
    localparam int W     = SLICE_W * WORDS
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         carryIn,
    input  logic         sub,
    output logic [W-1:0] sum,
    output logic         carryOut,
    output logic         overflow,
    output logic         out_valid,
    input  logic         out_ready
);
    localparam int K_W = $clog2(WORDS);

    state_t               state, next;
    logic [W-1:0]         a_q, b_q;
    logic                 carry;
    logic [K_W-1:0]       k;
    logic [W-1:0]         b_eff;
    logic                 cin_eff;
    logic [SLICE_W-1:0]   s;
    logic                 co;
    logic                 last;
    logic                 accept;

`ifdef MULTIWORD_ADD_SUB_EN
    assign b_eff   = sub ? ~b : b;
    assign cin_eff = sub | carryIn;
`else
    logic unused_sub;
    assign unused_sub = sub;
    assign b_eff      = b;
    assign cin_eff    = carryIn;
`endif

    assign in_ready  = state == IDLE;
    assign out_valid = state == DONE;
    assign accept    = in_ready && in_valid;
    assign last      = k == K_W'(WORDS - 1);

    carry_select_adder u_add (
        .a    (a_q[k*SLICE_W +: SLICE_W]),
        .b    (b_q[k*SLICE_W +: SLICE_W]),
        .cin  (carry),
        .sum  (s),
        .cout (co)
    );

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next;
    end

    // next-state: accept in IDLE, finish after the top slice, hand off on out_ready
    always_comb begin
        next = state;
        case (state)
            IDLE:    next = in_valid ? RUN : IDLE;
            RUN:     next = last ? DONE : RUN;
            DONE:    next = out_ready ? IDLE : DONE;
            default: next = IDLE;
        endcase
    end

    // datapath: latch operands on accept, then fold one slice per RUN cycle into the result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q      <= '0;
            b_q      <= '0;
            carry    <= 1'b0;
            k        <= '0;
            sum      <= '0;
            carryOut <= 1'b0;
            overflow <= 1'b0;
        end else if (accept) begin
            a_q   <= a;
            b_q   <= b_eff;
            carry <= cin_eff;
            k     <= '0;
        end else if (state == RUN) begin
            sum[k*SLICE_W +: SLICE_W] <= s;
            carry <= co;
            k     <= last ? '0 : k + K_W'(1);
            if (last) begin
                carryOut <= co;
                overflow <= (a_q[W-1] == b_q[W-1]) && (s[SLICE_W-1] != a_q[W-1]);
            end
        end
    end
endmodule

// File: tb/tb_multiword_add_ctrl.sv
// tb_multiword_add_ctrl: randomized and directed checks of multiword_add_ctrl against an arithmetic model
module tb_multiword_add_ctrl;
    localparam int WORDS = 4;
    localparam int W     = 16 * WORDS;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         carryIn = 1'b0;
    logic         sub = 1'b0;
    logic [W-1:0] sum;
    logic         carryOut;
    logic         overflow;
    logic         out_valid;
    logic         out_ready = 1'b0;

    int vectors = 0;
    int miscompares = 0;

    multiword_add_ctrl #(.WORDS(WORDS)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .carryIn(carryIn), .sub(sub),
        .sum(sum), .carryOut(carryOut), .overflow(overflow),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [W:0] act, input logic [W:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Model: ph=0 idle, 1..WORDS busy computing, WORDS+1 result held.
    // The result itself comes straight from wide arithmetic on the accepted operands.
    int           ph = 0;
    logic [W-1:0] m_sum = '0, p_sum;
    logic         m_co = 1'b0, m_ovf = 1'b0, p_co, p_ovf;

    function automatic logic [W+1:0] golden(input logic [W-1:0] x, input logic [W-1:0] y,
                                            input logic c, input logic s);
        logic [W-1:0] ye;
        logic         ce;
        logic [W:0]   full;
        ye = y;
        ce = c;
`ifdef MULTIWORD_ADD_SUB_EN
        if (s) begin
            ye = ~y;
            ce = 1'b1;
        end
`endif
        full = {1'b0, x} + {1'b0, ye} + {{W{1'b0}}, ce};
        return {(x[W-1] == ye[W-1]) && (full[W-1] != x[W-1]), full};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ph = 0;
            m_sum = '0;
            m_co = 1'b0;
            m_ovf = 1'b0;
        end else if (ph == 0) begin
            if (in_valid) begin
                {p_ovf, p_co, p_sum} = golden(a, b, carryIn, sub);
                ph = 1;
            end
        end else if (ph <= WORDS) begin
            ph++;
            if (ph == WORDS + 1) begin
                m_sum = p_sum;
                m_co  = p_co;
                m_ovf = p_ovf;
            end
        end else if (out_ready) begin
            ph = 0;
        end
    end

    // compare every cycle; sum is only meaningful outside the busy phase
    always @(negedge clk) begin
        chk("in_ready", {{W{1'b0}}, in_ready}, {{W{1'b0}}, ph == 0});
        chk("out_valid", {{W{1'b0}}, out_valid}, {{W{1'b0}}, ph == WORDS + 1});
        chk("carryOut", {{W{1'b0}}, carryOut}, {{W{1'b0}}, m_co});
        chk("overflow", {{W{1'b0}}, overflow}, {{W{1'b0}}, m_ovf});
        if (ph == 0 || ph == WORDS + 1) chk("sum", {1'b0, sum}, {1'b0, m_sum});
    end

    function automatic logic [W-1:0] rnd_word();
        case ($urandom_range(0, 5))
            0:       return '1;
            1:       return {1'b0, {(W-1){1'b1}}};
            2:       return {1'b1, {(W-1){1'b0}}};
            3:       return W'($urandom_range(0, 3));
            default: return {$urandom, $urandom};
        endcase
    endfunction

    task automatic start_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic c, input logic s);
        int n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("start_timeout", {{W{1'b0}}, in_ready}, {{W{1'b0}}, 1'b1});
        a = x;
        b = y;
        carryIn = c;
        sub = s;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic c, input logic s,
                         input int hold, input bit lit, input logic [W:0] exp_cs, input logic exp_ov);
        int n = 0;
        start_op(x, y, c, s);
        while (!out_valid && n < 50) begin
            in_valid = 1'($urandom_range(0, 1));
            a = rnd_word();
            b = rnd_word();
            @(posedge clk); #1;
            n++;
        end
        in_valid = 1'b0;
        chk("done_timeout", {{W{1'b0}}, out_valid}, {{W{1'b0}}, 1'b1});
        if (lit) begin
            chk("lit_sum", {carryOut, sum}, exp_cs);
            chk("lit_ovf", {{W{1'b0}}, overflow}, {{W{1'b0}}, exp_ov});
        end
        repeat (hold) begin
            in_valid = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
        in_valid = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        chk("handoff_idle", {{W{1'b0}}, in_ready}, {{W{1'b0}}, 1'b1});
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("reset_sum", {carryOut, sum}, '0);
        rst_n = 1'b1;
        do_op(64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 1'b0, 0, 1'b1, {1'b0, 64'h0000_0000_0001_0000}, 1'b0);
        do_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 1'b0, 1, 1'b1, {1'b1, 64'h0}, 1'b0);
        do_op(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 10, 1'b1, {1'b0, 64'h8000_0000_0000_0000}, 1'b1);
`ifdef MULTIWORD_ADD_SUB_EN
        do_op(64'h5, 64'h7, 1'b0, 1'b1, 2, 1'b1, {1'b0, 64'hFFFF_FFFF_FFFF_FFFE}, 1'b0);
`endif
        start_op(64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222, 1'b0, 1'b0);
        repeat (2) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #1;
        chk("rst_out_valid", {{W{1'b0}}, out_valid}, '0);
        chk("rst_sum", {carryOut, sum}, '0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("rst_in_ready", {{W{1'b0}}, in_ready}, {{W{1'b0}}, 1'b1});
        do_op(64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222, 1'b0, 1'b0, 0, 1'b1,
              {1'b0, 64'h3333_3333_3333_3333}, 1'b0);
        for (int i = 0; i < 80; i++)
            do_op(rnd_word(), rnd_word(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  int'($urandom_range(0, 3)), 1'b0, '0, 1'b0);
        @(posedge clk); #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
